// File: rtl/zbt_pkg.sv
// Shared definitions for the pipelined ZBT SRAM controller.
// ZBT_SNOOZE_EN enables the idle snooze/wake states.
package zbt_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 32;
    localparam int ZBT_BE_W   = 4;

    localparam int ZBT_WR_LAT = 2;
    localparam int ZBT_RD_LAT = 4;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_WAKE   = 2'd3
    } zbt_state_e;

    function automatic logic [ZBT_BE_W-1:0] zbt_bw_n(
        input logic                we,
        input logic [ZBT_BE_W-1:0] be
    );
        return we ? ~be : {ZBT_BE_W{1'b1}};
    endfunction

endpackage

// File: rtl/zbt_sram_ctrl_if.sv
// Client request/response bundle for zbt_sram_ctrl.
// master = client logic, slave = controller.
interface zbt_sram_ctrl_if
    import zbt_pkg::*;
#(
    parameter int ADDR_W = ZBT_ADDR_W,
    parameter int DATA_W = ZBT_DATA_W
);

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [ZBT_BE_W-1:0] req_be;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_be,
        input  req_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        output req_ready,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/zbt_pipe_delay.sv
// Fixed-depth valid+data shift register used to line up
// write data and read tags with the ZBT pipeline.
module zbt_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/zbt_sram_ctrl.sv
// Full-rate single-port controller for a pipelined 32-bit ZBT SRAM.
// Define ZBT_SNOOZE_EN to add the idle snooze (ZZ) states.
module zbt_sram_ctrl
    import zbt_pkg::*;
#(
    parameter int ADDR_W      = ZBT_ADDR_W,
    parameter int DATA_W      = ZBT_DATA_W,
    parameter int INIT_CYCLES = 16
`ifdef ZBT_SNOOZE_EN
    ,
    parameter int IDLE_LIMIT  = 256,
    parameter int WAKE_CYCLES = 2
`endif
) (
    input  logic                clk,
    input  logic                reset,
    zbt_sram_ctrl_if.slave      req,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_we_n,
    output logic [ZBT_BE_W-1:0] sram_bw_n,
    output logic                sram_ce_n,
    output logic                sram_ld_n,
    output logic                sram_cke_n,
    output logic                sram_oe_n,
    output logic                sram_ce2,
    output logic                sram_ce2_n,
    output logic                sram_lbo_n,
    output logic                sram_zz,
    output logic [DATA_W-1:0]   dq_out,
    output logic                dq_oe,
    input  logic [DATA_W-1:0]   dq_in
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    zbt_state_e        state_q;
    logic [INIT_W-1:0] init_cnt_q;
    logic              accept;

    assign req.req_ready = (state_q == ST_RUN);
    assign accept        = req.req_valid && req.req_ready;

`ifdef ZBT_SNOOZE_EN
    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    logic [IDLE_W-1:0]     idle_q;
    logic [WAKE_W-1:0]     wake_q;
    logic                  zz_q;
    logic [ZBT_RD_LAT-1:0] hist_q;
    logic                  inflight;

    // hist_q covers every edge up to the last response of an access
    assign inflight = |hist_q;
    assign sram_zz  = zz_q;
`else
    assign sram_zz  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_W'(INIT_CYCLES - 1);
`ifdef ZBT_SNOOZE_EN
            idle_q     <= '0;
            wake_q     <= '0;
            zz_q       <= 1'b0;
            hist_q     <= '0;
`endif
        end else begin
`ifdef ZBT_SNOOZE_EN
            hist_q <= {hist_q[ZBT_RD_LAT-2:0], accept};
`endif
            unique case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        init_cnt_q <= init_cnt_q - INIT_W'(1);
                    end
                end
`ifdef ZBT_SNOOZE_EN
                ST_RUN: begin
                    if (req.req_valid || inflight) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_W'(IDLE_LIMIT - 1)) begin
                        idle_q  <= '0;
                        zz_q    <= 1'b1;
                        state_q <= ST_SNOOZE;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
                ST_SNOOZE: begin
                    if (req.req_valid) begin
                        zz_q    <= 1'b0;
                        wake_q  <= WAKE_W'(WAKE_CYCLES - 1);
                        state_q <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        wake_q <= wake_q - WAKE_W'(1);
                    end
                end
`else
                ST_RUN: state_q <= ST_RUN;
`endif
                default: state_q <= ST_INIT;
            endcase
        end
    end

    logic                v0_q;
    logic                we0_q;
    logic [ADDR_W-1:0]   addr0_q;
    logic [ZBT_BE_W-1:0] be0_q;
    logic [DATA_W-1:0]   wdata0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q     <= 1'b0;
            we0_q    <= 1'b0;
            addr0_q  <= '0;
            be0_q    <= '0;
            wdata0_q <= '0;
        end else begin
            v0_q <= accept;
            if (accept) begin
                we0_q    <= req.req_we;
                addr0_q  <= req.req_addr;
                be0_q    <= req.req_be;
                wdata0_q <= req.req_wdata;
            end
        end
    end

    logic                ce_n_q;
    logic                we_n_q;
    logic [ZBT_BE_W-1:0] bw_n_q;
    logic [ADDR_W-1:0]   addr_q;

    // Idle slots become deselects; the address simply holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_n_q <= 1'b1;
            we_n_q <= 1'b1;
            bw_n_q <= '1;
            addr_q <= '0;
        end else if (v0_q) begin
            ce_n_q <= 1'b0;
            we_n_q <= ~we0_q;
            bw_n_q <= zbt_bw_n(we0_q, be0_q);
            addr_q <= addr0_q;
        end else begin
            ce_n_q <= 1'b1;
            we_n_q <= 1'b1;
            bw_n_q <= '1;
        end
    end

    logic              wr_v;
    logic [DATA_W-1:0] wr_data;
    logic              rd_tag_v;
    logic [0:0]        rd_tag_rd;
    logic              rd_hit_d;

    zbt_pipe_delay #(
        .DEPTH (ZBT_WR_LAT),
        .W     (DATA_W)
    ) u_wr_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (v0_q && we0_q),
        .in_data_i   (wdata0_q),
        .out_valid_o (wr_v),
        .out_data_o  (wr_data)
    );

    zbt_pipe_delay #(
        .DEPTH (ZBT_RD_LAT - 1),
        .W     (1)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (v0_q),
        .in_data_i   (~we0_q),
        .out_valid_o (rd_tag_v),
        .out_data_o  (rd_tag_rd)
    );

    assign rd_hit_d = rd_tag_v && rd_tag_rd[0];

    logic              dq_oe_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            dq_oe_q    <= wr_v;
            rd_valid_q <= rd_hit_d;
            if (wr_v) begin
                dq_out_q <= wr_data;
            end
            if (rd_hit_d) begin
                rd_data_q <= dq_in;
            end
        end
    end

    assign req.rd_valid = rd_valid_q;
    assign req.rd_data  = rd_data_q;

    assign sram_addr  = addr_q;
    assign sram_we_n  = we_n_q;
    assign sram_bw_n  = bw_n_q;
    assign sram_ce_n  = ce_n_q;
    assign dq_out     = dq_out_q;
    assign dq_oe      = dq_oe_q;

    assign sram_ld_n  = 1'b0;
    assign sram_cke_n = 1'b0;
    assign sram_oe_n  = 1'b0;
    assign sram_ce2   = 1'b1;
    assign sram_ce2_n = 1'b0;
    assign sram_lbo_n = 1'b0;

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// Scoreboard bench for zbt_sram_ctrl with a behavioural ZBT model.
// Define ZBT_SNOOZE_EN to also exercise snooze/wake.
module tb_zbt_sram_ctrl;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] sram_addr;
    logic        sram_we_n;
    logic [3:0]  sram_bw_n;
    logic        sram_ce_n;
    logic        sram_ld_n;
    logic        sram_cke_n;
    logic        sram_oe_n;
    logic        sram_ce2;
    logic        sram_ce2_n;
    logic        sram_lbo_n;
    logic        sram_zz;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic [31:0] dq_in = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    exp_t cmd_q[$];
    exp_t wr_q[$];
    exp_t rd_q[$];

    zbt_sram_ctrl_if #(.ADDR_W(19), .DATA_W(32)) bus ();

    zbt_sram_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_bw_n  (sram_bw_n),
        .sram_ce_n  (sram_ce_n),
        .sram_ld_n  (sram_ld_n),
        .sram_cke_n (sram_cke_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce2   (sram_ce2),
        .sram_ce2_n (sram_ce2_n),
        .sram_lbo_n (sram_lbo_n),
        .sram_zz    (sram_zz),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .dq_in      (dq_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Pipelined ZBT model: command at edge E, write data at E+2,
    // read data driven after E+1 so it is captured at E+2.
    logic [31:0] mem [int];
    logic        m_drv = 1'b0;
    logic        a_v = 1'b0, a_w = 1'b0, b_v = 1'b0, b_w = 1'b0;
    logic [18:0] a_addr = '0, b_addr = '0;
    logic [3:0]  a_bw = 4'hF, b_bw = 4'hF;

    always @(posedge clk) begin
        logic [31:0] w;
        if (b_v && b_w && dq_oe) begin
            w = mem.exists(int'(b_addr)) ? mem[int'(b_addr)] : 32'h0;
            for (int l = 0; l < 4; l++) begin
                if (!b_bw[l]) w[8*l +: 8] = dq_out[8*l +: 8];
            end
            mem[int'(b_addr)] = w;
        end
        if (a_v && !a_w) begin
            dq_in <= mem.exists(int'(a_addr)) ? mem[int'(a_addr)] : 32'h0;
            m_drv <= 1'b1;
        end else begin
            dq_in <= 32'h0;
            m_drv <= 1'b0;
        end
        b_v = a_v;  b_w = a_w;  b_addr = a_addr;  b_bw = a_bw;
        a_v = !sram_ce_n;  a_w = !sram_we_n;
        a_addr = sram_addr;  a_bw = sram_bw_n;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!sram_ce_n) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexp_ce_n", sram_ce_n, 1);
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_cycle", cyc, e.cyc);
                chk("cmd_pins", {sram_we_n, sram_bw_n, sram_addr}, e.val);
            end
        end else begin
            chk("deselect", {sram_we_n, sram_bw_n}, 5'h1F);
        end
        if (dq_oe) begin
            chk("contention", m_drv, 0);
            if (wr_q.size() == 0) begin
                chk("wr_unexp_dq_oe", dq_oe, 0);
            end else begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_data", dq_out, e.val);
            end
        end
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexp_valid", bus.rd_valid, 0);
            end else begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_data", bus.rd_data, e.val);
            end
        end
    end

    // Entered and left at a negedge; accepted at the next posedge T.
    task automatic issue(input logic we, input logic [18:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] rexp, input bit drop,
                         output int waited);
        int t;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_be    = be;
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            chk("ready_timeout", bus.req_ready, 1);
            bus.req_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        if (!(drop && !we)) begin
            cmd_q.push_back('{t + 1,
                64'({~we, (we ? ~be : 4'hF), addr})});
        end
        if (!drop) begin
            if (we) wr_q.push_back('{t + 3, 64'(wd)});
            else    rd_q.push_back('{t + 4, 64'(rexp)});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic init_check();
        for (int k = 1; k <= 17; k++) begin
            chk("init_ready", bus.req_ready, (k == 17));
            if (k < 17) @(negedge clk);
        end
    endtask

    localparam logic [31:0] WD [8] = '{
        32'h0101_0101, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000,
        32'h8000_0001, 32'hCAFE_F00D, 32'h5A5A_A5A5, 32'h7654_3210
    };

    initial begin
        int w;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_bw_n", sram_bw_n, 4'hF);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq", {dq_oe, dq_out}, 0);
        chk("rst_rd", {bus.rd_valid, bus.rd_data}, 0);
        reset = 1'b0;
        init_check();

        issue(1, 19'h00010, 32'hDEADBEEF, 4'b0101, 0, 0, w);
        issue(0, 19'h00010, 0, 0, 32'h00AD00EF, 0, w);

        for (int i = 0; i < 8; i++) begin
            issue(1, 19'(i), WD[i], 4'hF, 0, 0, w);
            chk("ready_b2b_w", w, 0);
            issue(0, 19'(i), 0, 0, WD[i], 0, w);
            chk("ready_b2b_r", w, 0);
        end

        issue(1, 19'h00010, 32'h12345678, 4'b1000, 0, 0, w);
        issue(0, 19'h00010, 0, 0, 32'h12AD00EF, 0, w);
        issue(1, 19'h7FFFF, 32'h0BADCAFE, 4'hF, 0, 0, w);
        issue(0, 19'h7FFFF, 0, 0, 32'h0BADCAFE, 0, w);
        repeat (6) @(negedge clk);

        issue(1, 19'h00020, 32'h55AA55AA, 4'hF, 0, 1, w);
        issue(0, 19'h00020, 0, 0, 0, 1, w);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_dq_oe", dq_oe, 0);
        reset = 1'b0;
        init_check();

        issue(0, 19'h00010, 0, 0, 32'h12AD00EF, 0, w);
        repeat (8) @(negedge clk);

`ifdef ZBT_SNOOZE_EN
        w = 0;
        while (!sram_zz && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("zz_set", sram_zz, 1);
        chk("zz_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 19'h00010;
        @(negedge clk);
        chk("wake_zz", sram_zz, 0);
        chk("wake_ready0", bus.req_ready, 0);
        @(negedge clk);
        chk("wake_ready1", bus.req_ready, 0);
        @(negedge clk);
        issue(0, 19'h00010, 0, 0, 32'h12AD00EF, 0, w);
        chk("wake_accept", w, 0);
        repeat (8) @(negedge clk);
`else
        chk("zz_const", sram_zz, 0);
`endif

        chk("const_pins", {sram_ld_n, sram_cke_n, sram_oe_n,
                           sram_ce2, sram_ce2_n, sram_lbo_n}, 6'b000100);
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
